mirror_display_scan: RTL

MIRROR_DISPLAY_SCAN -- requirements
Module: mirror_display_scan

---
 rtl/mirror_display_scan.sv | 86 ++++++++
 1 files changed

// File: rtl/mirror_display_scan.sv
// mirror_display_scan
//   Shows one of CHANNELS packed data channels on a registered display.
//   In manual mode the channel follows sel. Out-of-range sel values are
//   ignored. In auto-scan mode the channel advances after DWELL cycles, or
//   at once on next_pulse. hold freezes all state.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   data_in      packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//   sel          manual channel select
//   mode         0 = manual, 1 = auto-scan
//   next_pulse   single-cycle request to advance one channel (auto only)
//   hold         freezes display, chan and dwell counter while high
//   display      registered value of the current channel
//   chan         index of the channel on display
//   chan_changed one-cycle pulse coincident with a change of chan
module mirror_display_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 100000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      next_pulse,
    input  logic                      hold,
    output logic [WIDTH-1:0]          display,
    output logic [SEL_W-1:0]          chan,
    output logic                      chan_changed
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [SEL_W-1:0] chan_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            ch_data[k] = data_in[k*WIDTH +: WIDTH];
        end
    end

    // Manual mode parks the dwell counter at 0. A manual-to-auto switch
    // therefore starts a fresh dwell on the channel already shown.
    // next_pulse and dwell expiry share one advance path. When both happen
    // in the same cycle, the channel moves by a single step.
    always_comb begin
        chan_next = chan;
        cnt_next  = '0;
        if (!mode) begin
            if ({1'b0, sel} < NUM_CH) begin
                chan_next = sel;
            end
        end else if (next_pulse || (cnt == LAST_CNT)) begin
            chan_next = (chan == LAST_CH) ? '0 : chan + 1'b1;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display      <= '0;
            chan         <= '0;
            cnt          <= '0;
            chan_changed <= 1'b0;
        end else if (!hold) begin
            display      <= ch_data[chan_next];
            chan         <= chan_next;
            cnt          <= cnt_next;
            chan_changed <= (chan_next != chan);
        end else begin
            chan_changed <= 1'b0;
        end
    end

endmodule
